// File: rtl/hp35_sram_arbiter.sv
// Two-requester arbiter for the 256x30 microcode SRAM: HP-35 core fetch (priority) and Wishbone.
// Optional write lock is enabled by defining HP35_SRAM_WR_LOCK_EN.
module hp35_sram_arbiter #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned WB_MAX_WAIT = 16,
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 30
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    output logic          core_gnt,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          sram_csb0,
    output logic          sram_web0,
    output logic [AW-1:0] sram_addr0,
    output logic [DW-1:0] sram_din0,
    input  logic [DW-1:0] sram_dout0,
`ifdef HP35_SRAM_WR_LOCK_EN
    input  logic          wr_lock,
    output logic          wr_violation,
`endif
    output logic          arb_owner
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    localparam logic [7:0] MaxWait = 8'(WB_MAX_WAIT);

    state_e     state_q;
    logic [7:0] starve_q;
    logic       wb_we_q;

    logic in_window, wb_strobe, wb_valid, oow_valid;
    logic wb_force, core_win, wb_win, wr_allowed;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:DW]};

    always_comb begin
        in_window = (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
        wb_strobe = wbs_cyc_i & wbs_stb_i;
        // The ack cycle itself must not be mistaken for a fresh request.
        wb_valid  = wb_strobe & in_window & ~wbs_ack_o;
        oow_valid = wb_strobe & ~in_window & ~wbs_ack_o;
        wb_force  = wb_valid & (starve_q == MaxWait);
        core_win  = core_req & ~wb_force;
        wb_win    = ~core_win & wb_valid;
`ifdef HP35_SRAM_WR_LOCK_EN
        wr_allowed = (|wbs_sel_i) & ~wr_lock;
`else
        wr_allowed = |wbs_sel_i;
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            wb_we_q     <= 1'b0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            core_gnt    <= 1'b0;
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            arb_owner   <= 1'b0;
`ifdef HP35_SRAM_WR_LOCK_EN
            wr_violation <= 1'b0;
`endif
        end else begin
            core_gnt    <= 1'b0;
            core_rvalid <= 1'b0;
            wbs_ack_o   <= 1'b0;
            if (!wb_valid) starve_q <= '0;

            unique case (state_q)
                StIdle: begin
                    if (core_win) begin
                        core_gnt   <= 1'b1;
                        sram_addr0 <= core_addr;
                        sram_csb0  <= 1'b0;
                        wb_we_q    <= 1'b0;
                        arb_owner  <= 1'b0;
                        state_q    <= StIssue;
                        if (wb_valid && starve_q != MaxWait) starve_q <= starve_q + 8'd1;
                    end else if (wb_win) begin
                        sram_addr0 <= wbs_adr_i[AW+1:2];
                        sram_din0  <= wbs_dat_i[DW-1:0];
                        sram_csb0  <= 1'b0;
                        sram_web0  <= ~(wbs_we_i & wr_allowed);
                        wb_we_q    <= wbs_we_i;
                        arb_owner  <= 1'b1;
                        starve_q   <= '0;
                        state_q    <= StIssue;
`ifdef HP35_SRAM_WR_LOCK_EN
                        if (wbs_we_i && wr_lock) wr_violation <= 1'b1;
`endif
                    end
                end
                StIssue: begin
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    if (arb_owner && wb_we_q) begin
                        wbs_ack_o <= wb_strobe;
                        state_q   <= StResp;
                    end else begin
                        state_q   <= StCapture;
                    end
                end
                StCapture: begin
                    if (arb_owner) begin
                        wbs_dat_o <= {{(32-DW){1'b0}}, sram_dout0};
                        wbs_ack_o <= wb_strobe;
                    end else begin
                        core_rdata  <= sram_dout0;
                        core_rvalid <= 1'b1;
                    end
                    state_q <= StResp;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            // Out-of-window accesses bypass the FSM entirely.
            if (oow_valid) begin
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hp35_sram_arbiter.sv
// Directed bench for hp35_sram_arbiter with a behavioural SRAM and response scoreboards.
module tb_hp35_sram_arbiter;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [7:0]  core_addr;
    logic        core_gnt;
    logic [29:0] core_rdata;
    logic        core_rvalid;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sram_csb0, sram_web0;
    logic [7:0]  sram_addr0;
    logic [29:0] sram_din0;
    logic [29:0] sram_dout0;
    logic        arb_owner;
`ifdef HP35_SRAM_WR_LOCK_EN
    logic        wr_lock;
    logic        wr_violation;
`endif

    logic [29:0] mem [256];
    int          csb_low_cnt = 0;
    int          web_low_cnt = 0;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] wb_exp_q[$];
    logic [29:0] core_exp_q[$];

    always #5 clk = ~clk;

    hp35_sram_arbiter dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_gnt    (core_gnt),
        .core_rdata  (core_rdata),
        .core_rvalid (core_rvalid),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_w),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
`ifdef HP35_SRAM_WR_LOCK_EN
        .wr_lock     (wr_lock),
        .wr_violation(wr_violation),
`endif
        .arb_owner   (arb_owner)
    );

    // Single-port SRAM: read data appears one cycle after the access edge.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else            sram_dout0 <= mem[sram_addr0];
            csb_low_cnt <= csb_low_cnt + 1;
            if (!sram_web0) web_low_cnt <= web_low_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one Wishbone cycle; lat = samples until ack, -1 on timeout.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (wbs_ack_o) begin
                lat = i;
                rd  = wbs_dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          lat, c0, cnt, gnt_cnt, rv_cnt, last_gnt, ack_at, gnt_at_ack, next_gnt;
        logic [31:0] rd;

        rst = 1'b1; core_req = 1'b0; core_addr = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0;
`ifdef HP35_SRAM_WR_LOCK_EN
        wr_lock = 1'b0;
`endif
        mem[8'h20] <= 30'h155;
        mem[8'h05] <= 30'h3;
        mem[8'h00] <= 30'h0AA;
        repeat (3) tick();

        chk("rst_csb0", 32'(sram_csb0), 32'd1);
        chk("rst_web0", 32'(sram_web0), 32'd1);
        chk("rst_addr0", 32'(sram_addr0), 32'd0);
        chk("rst_din0", 32'(sram_din0), 32'd0);
        chk("rst_gnt_rvalid_ack", {29'd0, core_gnt, core_rvalid, wbs_ack_o}, 32'd0);
        chk("rst_core_rdata", 32'(core_rdata), 32'd0);
        chk("rst_dat_o", wbs_dat_o, 32'd0);
        chk("rst_owner", 32'(arb_owner), 32'd0);
        chk("rst_starve", 32'(dut.starve_q), 32'd0);
        rst = 1'b0;
        tick();

        // Write then read back through the window
        c0 = web_low_cnt;
        wb_xfer(1'b1, BASE + 32'h10, 32'h2ABC_DEF1, 4'hF, lat, rd);
        chk("wr_latency", lat, 32'd2);
        chk("wr_mem4", 32'(mem[8'h04]), 32'h2ABC_DEF1);
        chk("wr_web_pulses", web_low_cnt - c0, 32'd1);
        tick();
        wb_exp_q.push_back(32'h2ABC_DEF1);
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, lat, rd);
        chk("rd_latency", lat, 32'd3);
        chk("rd_data", rd, wb_exp_q.pop_front());
        chk("rd_owner", 32'(arb_owner), 32'd1);
        tick();

        // Outside the window
        c0 = csb_low_cnt;
        wb_xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF, lat, rd);
        chk("oow_latency", lat, 32'd1);
        chk("oow_data", rd, 32'd0);
        chk("oow_no_sram", csb_low_cnt - c0, 32'd0);
        tick();

        // sel=0 write: acked like a write, SRAM untouched
        c0 = web_low_cnt;
        wb_xfer(1'b1, BASE + 32'h14, 32'h123, 4'h0, lat, rd);
        chk("sel0_latency", lat, 32'd2);
        chk("sel0_mem5", 32'(mem[8'h05]), 32'h3);
        chk("sel0_no_web", web_low_cnt - c0, 32'd0);
        tick();

        // cyc dropped mid-access: no ack
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
        tick();
        cyc = 1'b0; stb = 1'b0;
        cnt = 0;
        repeat (6) begin
            tick();
            if (wbs_ack_o) cnt++;
        end
        chk("cyc_drop_no_ack", cnt, 32'd0);

        // Core request held continuously
        core_addr = 8'h20; core_req = 1'b1;
        gnt_cnt = 0; rv_cnt = 0; last_gnt = -100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 20) core_req = 1'b0;
            if (core_gnt) begin
                if (gnt_cnt == 0) chk("core_first_gnt", i, 32'd1);
                else              chk("core_gnt_spacing", i - last_gnt, 32'd4);
                last_gnt = i;
                gnt_cnt++;
                core_exp_q.push_back(30'h155);
            end
            if (core_rvalid) begin
                rv_cnt++;
                chk("core_rvalid_delay", i - last_gnt, 32'd2);
                if (core_exp_q.size() > 0) chk("core_rdata", 32'(core_rdata), 32'(core_exp_q.pop_front()));
                else chk("core_unexpected_rvalid", 32'd1, 32'd0);
            end
        end
        chk("core_gnt_count", gnt_cnt, 32'd5);
        chk("core_rvalid_count", rv_cnt, 32'd5);
        tick();

        // Starvation: Wishbone read forced through after 16 core wins
        core_req = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
        wb_exp_q.push_back(32'h2ABC_DEF1);
        gnt_cnt = 0; ack_at = -1; gnt_at_ack = -1; next_gnt = -1;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (core_gnt) begin
                gnt_cnt++;
                if (ack_at >= 0 && next_gnt < 0) begin
                    next_gnt = i;
                    core_req = 1'b0;
                end
            end
            if (wbs_ack_o) begin
                ack_at = i;
                gnt_at_ack = gnt_cnt;
                chk("starve_rd_data", wbs_dat_o, wb_exp_q.pop_front());
                chk("starve_owner", 32'(arb_owner), 32'd1);
                cyc = 1'b0; stb = 1'b0;
            end
            if (next_gnt >= 0 && i >= next_gnt + 4) break;
        end
        chk("starve_core_wins", gnt_at_ack, 32'd16);
        chk("starve_core_next", next_gnt - ack_at, 32'd2);
        core_req = 1'b0;
        cyc = 1'b0; stb = 1'b0;
        repeat (4) tick();

        // Reset during ISSUE of a write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h18; dat_w = 32'h77; sel = 4'hF;
        tick();
        chk("issue_csb_low", 32'(sram_csb0), 32'd0);
        rst = 1'b1;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("abort_csb0", 32'(sram_csb0), 32'd1);
        chk("abort_web0", 32'(sram_web0), 32'd1);
        chk("abort_ack", 32'(wbs_ack_o), 32'd0);
        chk("abort_state_idle", 32'(dut.state_q), 32'd0);
        chk("abort_starve", 32'(dut.starve_q), 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin
            tick();
            if (wbs_ack_o || core_gnt || core_rvalid) cnt++;
        end
        chk("abort_no_response", cnt, 32'd0);

`ifdef HP35_SRAM_WR_LOCK_EN
        chk("lock_violation_init", 32'(wr_violation), 32'd0);
        wr_lock = 1'b1;
        c0 = web_low_cnt;
        wb_xfer(1'b1, BASE, 32'h1, 4'hF, lat, rd);
        chk("lock_latency", lat, 32'd2);
        chk("lock_no_web", web_low_cnt - c0, 32'd0);
        chk("lock_mem0", 32'(mem[8'h00]), 32'h0AA);
        repeat (3) tick();
        chk("lock_violation_sticky", 32'(wr_violation), 32'd1);
        wr_lock = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lock_violation_reset", 32'(wr_violation), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
